console_port: RTL and testbench

//  CPU-side I/O responder for the MiniBit sequencer's display/input handshake.

---
 rtl/console_port_pkg.sv | 12 +
 rtl/console_port_sync_fifo.sv | 51 +++++
 rtl/console_port.sv | 122 ++++++++++++
 tb/tb_console_port.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/console_port_pkg.sv
// Shared definitions for the MiniBit console port: bus width and serve FSM encodings.
package console_port_pkg;

    localparam int BUS_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE   = 2'd1,
        ST_RELEASE = 2'd2
    } serve_state_t;

endpackage

// File: rtl/console_port_sync_fifo.sv
// Single-clock byte FIFO with an extra pointer bit for full/empty detection.
// A pop frees its slot before a push on the same edge, so full+push+pop is accepted.
module sync_fifo
    import console_port_pkg::*;
#(
    parameter int WIDTH = BUS_W,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head reads as zero while empty so the host never sees stale storage.
    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; both wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since head is masked when empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/console_port.sv
// CPU-side console responder: captures displayed bytes for the host and answers
// sequencer input stalls by driving one queued host byte onto the shared bus.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for hlt with input data available
// ST_SERVE   | rx high, bus driven with input head; pop on exit edge
// ST_RELEASE | bus released, waiting for hlt to drop before re-arming
module console_port
    import console_port_pkg::*;
#(
    parameter int OUT_DEPTH = 8,
    parameter int IN_DEPTH  = 8
) (
    input  logic             clk,
    input  logic             clear_n,
    inout  wire  [BUS_W-1:0] bus,
    input  logic             tx,
    input  logic             hlt,
    output logic             rx,
    output logic [BUS_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic [BUS_W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ovf
);

    serve_state_t     state;
    logic             bus_oe;
    logic             out_full;
    logic             out_empty;
    logic             out_push;
    logic             out_pop;
    logic             in_full;
    logic             in_empty;
    logic             in_push;
    logic             in_pop;
    logic [BUS_W-1:0] in_head;

    assign out_pop   = out_valid && out_ready;
    assign out_push  = tx && (!out_full || out_pop);
    assign out_valid = !out_empty;

    assign in_ready  = !in_full;
    assign in_push   = in_valid && in_ready;
    assign in_pop    = (state == ST_SERVE);

    // Only drive the shared bus while answering an input request.
    assign bus = bus_oe ? in_head : {BUS_W{1'bz}};

    sync_fifo #(
        .WIDTH (BUS_W),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .clear_n (clear_n),
        .push    (out_push),
        .pop     (out_pop),
        .din     (bus),
        .full    (out_full),
        .empty   (out_empty),
        .head    (out_data)
    );

    sync_fifo #(
        .WIDTH (BUS_W),
        .DEPTH (IN_DEPTH)
    ) u_in_fifo (
        .clk     (clk),
        .clear_n (clear_n),
        .push    (in_push),
        .pop     (in_pop),
        .din     (in_data),
        .full    (in_full),
        .empty   (in_empty),
        .head    (in_head)
    );

    // Serve FSM with registered rx and bus enable; RELEASE blocks re-serving one stall.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state  <= ST_IDLE;
            rx     <= 1'b0;
            bus_oe <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hlt && !in_empty) begin
                        state  <= ST_SERVE;
                        rx     <= 1'b1;
                        bus_oe <= 1'b1;
                    end
                end
                ST_SERVE: begin
                    state  <= ST_RELEASE;
                    rx     <= 1'b0;
                    bus_oe <= 1'b0;
                end
                ST_RELEASE: begin
                    if (!hlt) state <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    rx     <= 1'b0;
                    bus_oe <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow: a display byte was dropped because no slot could be freed.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            ovf <= 1'b0;
        end else if (tx && out_full && !out_pop) begin
            ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_console_port.sv
// Directed bench for console_port; the bus carries a pullup so an undriven bus reads 8'hFF.
module tb_console_port;

    logic       clk;
    logic       clear_n;
    logic       tx;
    logic       hlt;
    logic       rx;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       ovf;
    logic       tb_drv;
    logic [7:0] tb_val;
    wire  [7:0] bus;

    int checks = 0;
    int errors = 0;

    assign bus = tb_drv ? tb_val : 8'hzz;
    pullup (bus);

    console_port #(.OUT_DEPTH(8), .IN_DEPTH(8)) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .bus       (bus),
        .tx        (tx),
        .hlt       (hlt),
        .rx        (rx),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_n = 1'b0; tx = 1'b0; hlt = 1'b0; out_ready = 1'b0;
        in_data = 8'h00; in_valid = 1'b0; tb_drv = 1'b0; tb_val = 8'h00;
        #23 clear_n = 1'b1;
        tick();

        // Reset state
        chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_in_ready",  {7'd0, in_ready},  8'd1);
        chk("rst_ovf",       {7'd0, ovf},       8'd0);
        chk("rst_rx",        {7'd0, rx},        8'd0);
        chk("rst_out_data",  out_data,          8'h00);
        chk("rst_bus",       bus,               8'hFF);

        // 1: single display byte appears one clock later
        tb_drv = 1'b1; tb_val = 8'h41; tx = 1'b1;
        tick();
        tx = 1'b0; tb_drv = 1'b0;
        chk("t1_out_valid", {7'd0, out_valid}, 8'd1);
        chk("t1_out_data",  out_data,          8'h41);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t1_drained", {7'd0, out_valid}, 8'd0);

        // 2: nine strobes into an 8-deep FIFO -> overflow, host sees 1..8
        for (int i = 1; i <= 9; i++) begin
            tb_drv = 1'b1; tb_val = 8'(i); tx = 1'b1;
            tick();
        end
        tx = 1'b0; tb_drv = 1'b0;
        chk("t2_ovf", {7'd0, ovf}, 8'd1);
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            chk("t2_read", out_data, 8'(k));
            tick();
        end
        out_ready = 1'b0;
        chk("t2_empty",      {7'd0, out_valid}, 8'd0);
        chk("t2_ovf_sticky", {7'd0, ovf},       8'd1);

        // 3: queued byte served on hlt for exactly one clock
        in_data = 8'h5A; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; hlt = 1'b1;
        chk("t3_pre_rx",  {7'd0, rx}, 8'd0);
        chk("t3_pre_bus", bus,        8'hFF);
        tick();
        chk("t3_rx",  {7'd0, rx}, 8'd1);
        chk("t3_bus", bus,        8'h5A);
        tick();
        chk("t3_rx_off",  {7'd0, rx}, 8'd0);
        chk("t3_bus_off", bus,        8'hFF);
        hlt = 1'b0;
        tick();

        // 4: stall with empty input FIFO, then data arrives
        hlt = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t4_wait_rx",  {7'd0, rx}, 8'd0);
            chk("t4_wait_bus", bus,        8'hFF);
        end
        in_data = 8'h33; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t4_push_rx", {7'd0, rx}, 8'd0);
        tick();
        chk("t4_rx",  {7'd0, rx}, 8'd1);
        chk("t4_bus", bus,        8'h33);
        tick();
        hlt = 1'b0;
        tick();

        // 5: hlt held long after rx -> single pulse, single pop
        in_data = 8'hA1; in_valid = 1'b1;
        tick();
        in_data = 8'hA2;
        tick();
        in_valid = 1'b0; hlt = 1'b1;
        tick();
        chk("t5_rx",  {7'd0, rx}, 8'd1);
        chk("t5_bus", bus,        8'hA1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_hold_rx",  {7'd0, rx}, 8'd0);
            chk("t5_hold_bus", bus,        8'hFF);
        end
        hlt = 1'b0;
        tick();
        hlt = 1'b1;
        tick();
        chk("t5_rx2",  {7'd0, rx}, 8'd1);
        chk("t5_bus2", bus,        8'hA2);
        tick();
        hlt = 1'b0;
        tick();

        // 6: asynchronous reset in the middle of a serve
        in_data = 8'h77; in_valid = 1'b1;
        tb_drv = 1'b1; tb_val = 8'h10; tx = 1'b1;
        tick();
        in_valid = 1'b0; tx = 1'b0; tb_drv = 1'b0; hlt = 1'b1;
        tick();
        chk("t6_serving", {7'd0, rx}, 8'd1);
        #2 clear_n = 1'b0;
        #1;
        chk("t6_rx",        {7'd0, rx},        8'd0);
        chk("t6_bus",       bus,               8'hFF);
        chk("t6_out_valid", {7'd0, out_valid}, 8'd0);
        chk("t6_in_ready",  {7'd0, in_ready},  8'd1);
        chk("t6_ovf",       {7'd0, ovf},       8'd0);
        chk("t6_out_data",  out_data,          8'h00);
        #2 clear_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_in_empty_rx", {7'd0, rx}, 8'd0);
        end
        hlt = 1'b0;
        tick();

        // Full output FIFO with simultaneous push and pop: no overflow
        for (int i = 0; i < 8; i++) begin
            tb_drv = 1'b1; tb_val = 8'(8'h21 + i); tx = 1'b1;
            tick();
        end
        chk("fp_ovf_full", {7'd0, ovf}, 8'd0);
        tb_val = 8'h29; out_ready = 1'b1;
        tick();
        tx = 1'b0; tb_drv = 1'b0;
        chk("fp_ovf",  {7'd0, ovf}, 8'd0);
        for (int k = 0; k < 8; k++) begin
            chk("fp_read", out_data, 8'(8'h22 + k));
            tick();
        end
        out_ready = 1'b0;
        chk("fp_empty", {7'd0, out_valid}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
